// File: rtl/spi_clgen.sv
// spi_clgen: programmable serial clock generator with edge strobes for spi_shift.
// sclk toggles every divider+1 wb_clk cycles while enabled, parks at cpol when idle,
// and after the final bit returns to idle with a one-cycle done pulse.
module spi_clgen #(
    parameter int unsigned DIVIDER_LEN = 16
) (
    input  logic                   wb_clk,
    input  logic                   wb_reset,
    input  logic                   enable,
    input  logic                   go,
    input  logic                   last,
    input  logic                   cpol,
    input  logic [DIVIDER_LEN-1:0] divider,
    output logic                   sclk,
    output logic                   cpol_0,
    output logic                   cpol_1,
    output logic                   done
);

    localparam int unsigned CW = DIVIDER_LEN;

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          r_cpol_0;
    logic          r_cpol_1;
    logic          r_done;
    logic          r_armed;

    logic [CW-1:0] w_cnt_nxt;
    logic          w_sclk_nxt;
    logic          w_cpol_0_nxt;
    logic          w_cpol_1_nxt;
    logic          w_done_nxt;
    logic          w_armed_nxt;
    logic          w_cnt_zero;
    logic          w_toggle;
    logic          w_stop;

    // Half-period expiry and edge qualification; after last only a return-to-idle edge is allowed.
    assign w_cnt_zero = (r_cnt == '0);
    assign w_toggle   = enable & w_cnt_zero & (~last | (r_sclk ^ cpol));
    assign w_stop     = enable & last & r_armed & w_cnt_zero;

    // Next-state logic for counter, sclk, strobes and done qualification.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_sclk_nxt   = r_sclk;
        w_cpol_0_nxt = 1'b0;
        w_cpol_1_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_armed_nxt  = r_armed | go;
        if (!enable) begin
            // Preload so the first edge lands divider+1 cycles after enable rises.
            w_cnt_nxt  = divider;
            w_sclk_nxt = cpol;
        end else begin
            w_cnt_nxt    = w_cnt_zero ? divider : (r_cnt - CW'(1));
            w_sclk_nxt   = w_toggle ? ~r_sclk : r_sclk;
            w_cpol_0_nxt = w_toggle & ~r_sclk;
            w_cpol_1_nxt = w_toggle & r_sclk;
            // At this expiry sclk is either restored to cpol by the toggle or already there.
            if (w_stop) begin
                w_done_nxt  = 1'b1;
                w_armed_nxt = 1'b0;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge wb_clk or negedge wb_reset) begin
        if (!wb_reset) begin
            r_cnt    <= '1;
            r_sclk   <= 1'b0;
            r_cpol_0 <= 1'b0;
            r_cpol_1 <= 1'b0;
            r_done   <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_sclk   <= w_sclk_nxt;
            r_cpol_0 <= w_cpol_0_nxt;
            r_cpol_1 <= w_cpol_1_nxt;
            r_done   <= w_done_nxt;
            r_armed  <= w_armed_nxt;
        end
    end

    assign sclk   = r_sclk;
    assign cpol_0 = r_cpol_0;
    assign cpol_1 = r_cpol_1;
    assign done   = r_done;

endmodule

// File: tb/tb_spi_clgen.sv
// tb_spi_clgen: table-driven directed check of spi_clgen, one vector per wb_clk cycle.
module tb_spi_clgen;

    logic        wb_clk;
    logic        wb_reset;
    logic        enable;
    logic        go;
    logic        last;
    logic        cpol;
    logic [15:0] divider;
    logic        sclk;
    logic        cpol_0;
    logic        cpol_1;
    logic        done;

    int n_vec;
    int n_err;

    typedef struct {
        int          tst;
        logic        en;
        logic        go;
        logic        lst;
        logic        cp;
        logic [15:0] dv;
        logic [3:0]  exp;   // {sclk, cpol_0, cpol_1, done} after the edge
    } vec_t;

    vec_t vecs[$];
    int   cur_tst;

    spi_clgen #(.DIVIDER_LEN(16)) dut (
        .wb_clk   (wb_clk),
        .wb_reset (wb_reset),
        .enable   (enable),
        .go       (go),
        .last     (last),
        .cpol     (cpol),
        .divider  (divider),
        .sclk     (sclk),
        .cpol_0   (cpol_0),
        .cpol_1   (cpol_1),
        .done     (done)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic add(input logic en, input logic g, input logic lst, input logic cp,
                       input logic [15:0] dv, input logic [3:0] exp);
        vec_t v;
        v.tst = cur_tst; v.en = en; v.go = g; v.lst = lst; v.cp = cp; v.dv = dv; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One enabled half-period: 'waits' quiet cycles, then the edge with its strobe.
    task automatic add_half(input logic cp, input logic [15:0] dv, input int waits, input logic s0);
        for (int k = 0; k < waits; k++) add(1'b1, 1'b0, 1'b0, cp, dv, {s0, 3'b000});
        add(1'b1, 1'b0, 1'b0, cp, dv, {~s0, ~s0, s0, 1'b0});
    endtask

    task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got sclk/c0/c1/done=%b required %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge wb_clk);
        enable = v.en; go = v.go; last = v.lst; cpol = v.cp; divider = v.dv;
        @(posedge wb_clk);
        #1;
        check($sformatf("t%0d_v%0d", v.tst, idx), {sclk, cpol_0, cpol_1, done}, v.exp);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        wb_reset = 1'b0; enable = 1'b0; go = 1'b0; last = 1'b0; cpol = 1'b0; divider = 16'd3;

        // Test 1: cpol=0, divider=3, go armed in idle, 8 edges of period 8.
        cur_tst = 1;
        add(1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 4'b0000);
        for (int e = 0; e < 8; e++) add_half(1'b0, 16'd3, 3, logic'(e % 2));
        add(1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 4'b0000);

        // Test 2: divider=0 toggles every cycle with alternating strobes.
        cur_tst = 2;
        add(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'b0000);
        for (int e = 0; e < 6; e++) add_half(1'b0, 16'd0, 0, logic'(e % 2));

        // Test 3: cpol=1, divider=1, last while sclk=0 -> one rise back to idle with done.
        cur_tst = 3;
        add(1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 4'b1000);
        add_half(1'b1, 16'd1, 1, 1'b1);
        add_half(1'b1, 16'd1, 1, 1'b0);
        add_half(1'b1, 16'd1, 1, 1'b1);
        add(1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 4'b0000);
        add(1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 4'b1101);
        for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 4'b1000);
        add(1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 4'b1000);
        // go coincident with enable arms; sclk already idle -> done at next expiry, no edge.
        add(1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 4'b1000);
        add(1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 4'b1001);
        add(1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 4'b1000);
        add(1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 4'b1000);
        add(1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 4'b1000);

        // Test 4: divider 2 -> 5 mid half-period; current half stays 3 cycles.
        cur_tst = 4;
        add(1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 4'b0000);
        add_half(1'b0, 16'd2, 2, 1'b0);
        add_half(1'b0, 16'd5, 2, 1'b1);
        add_half(1'b0, 16'd5, 5, 1'b0);
        add_half(1'b0, 16'd5, 5, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 4'b0000);

        // Test 5: enable dropped while sclk=1 -> forced low with no strobe, then clean restart.
        cur_tst = 5;
        add(1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 4'b0000);
        add_half(1'b0, 16'd3, 3, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 4'b1000);
        add(1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 4'b0000);
        add_half(1'b0, 16'd3, 3, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 4'b0000);

        // Reset state, checked while reset is still held.
        repeat (2) @(posedge wb_clk);
        #1;
        check("reset_state", {sclk, cpol_0, cpol_1, done}, 4'b0000);
        @(negedge wb_clk);
        wb_reset = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Test 6: async reset mid-run right after a rise, then cpol=1 idle recovery.
        begin
            vec_t r;
            r.tst = 6; r.go = 1'b0; r.lst = 1'b0; r.cp = 1'b0; r.dv = 16'd3; r.en = 1'b1;
            for (int k = 0; k < 3; k++) begin
                r.exp = 4'b0000;
                apply(r, k);
            end
            r.exp = 4'b1100;
            apply(r, 3);
        end
        #2;
        wb_reset = 1'b0;
        #1;
        check("t6_async_reset", {sclk, cpol_0, cpol_1, done}, 4'b0000);
        enable = 1'b0; cpol = 1'b1;
        @(negedge wb_clk);
        wb_reset = 1'b1;
        #1;
        check("t6_post_release", {sclk, cpol_0, cpol_1, done}, 4'b0000);
        @(posedge wb_clk);
        #1;
        check("t6_idle_cpol1", {sclk, cpol_0, cpol_1, done}, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
